// File: rtl/axi_stream_insert_header_pkg.sv
// Shared definitions for the AXI-Stream header inserter: default bus width,
// FSM state encoding and byte-count / keep-mask helpers.
package axi_stream_insert_header_pkg;

  localparam int DATA_WD_DEF = 32;
  // Widest keep bus the helpers handle; callers zero-extend into it.
  localparam int MAX_KEEP_WD = 64;

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    FLUSH
  } state_e;

  // Number of set bits in a keep mask.
  function automatic int keep_to_count(input logic [MAX_KEEP_WD-1:0] keep);
    int cnt;
    cnt = 0;
    for (int i = 0; i < MAX_KEEP_WD; i++) begin
      cnt += int'(keep[i]);
    end
    return cnt;
  endfunction

  // Keep mask of 'width' bits with the top 'cnt' bits set (first bytes on the wire).
  function automatic logic [MAX_KEEP_WD-1:0] count_to_top_mask(input int cnt, input int width);
    logic [MAX_KEEP_WD-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_KEEP_WD; i++) begin
      if (i < width && i >= width - cnt) begin
        mask[i] = 1'b1;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/axis_byte_realign.sv
// Combinational byte re-packer: joins the n residual bytes held from the
// previous beat with the leading bytes of the current beat, and reports the
// keep mask for the resulting word.
module axis_byte_realign
  import axi_stream_insert_header_pkg::*;
#(
  parameter int DATA_WD      = DATA_WD_DEF,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic [DATA_WD-1:0]      residual,
  input  logic [BYTE_CNT_WD-1:0]  n,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [BYTE_CNT_WD-1:0]  m,
  output logic [DATA_WD-1:0]      packed_data,
  output logic [DATA_WD-1:0]      new_residual,
  output logic [DATA_BYTE_WD-1:0] keep
);

  int                 total;
  logic [DATA_WD-1:0] raw;

  // Residual occupies the low n bytes; shifting {residual, data_in} right by
  // n bytes places it at the MSB end followed by the head of data_in.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    packed_data = '0;
    total       = int'(n) + int'(m);
    if (total > DATA_BYTE_WD) begin
      total = DATA_BYTE_WD;
    end
    keep = DATA_BYTE_WD'(count_to_top_mask(total, DATA_BYTE_WD));
    raw  = DATA_WD'({residual, data_in} >> (8 * int'(n)));
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      packed_data[8*i +: 8] = raw[8*i +: 8] & {8{keep[i]}};
    end
    // Only the low n bytes are consumed next beat.
    new_residual = data_in;
  end

endmodule

// File: rtl/axi_stream_insert_header.sv
// AXI-Stream header inserter: prepends the valid header bytes to a packet and
// re-packs the stream so every output beat is full except the last.
module axi_stream_insert_header
  import axi_stream_insert_header_pkg::*;
#(
  parameter int DATA_WD      = DATA_WD_DEF,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,          // active-high despite the name
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      header_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  output logic                    ready_insert
);

  state_e                  state, state_nxt;
  logic [DATA_WD-1:0]      res_data, hdr_bits;
  logic [BYTE_CNT_WD-1:0]  res_cnt, flush_cnt, in_cnt, hdr_cnt;
  logic [DATA_WD-1:0]      ra_res, ra_data, ra_packed, ra_new_res;
  logic [BYTE_CNT_WD-1:0]  ra_n, ra_m;
  logic [DATA_BYTE_WD-1:0] ra_keep;
  logic                    can_load, load, load_last, hdr_fire, overflow;
  int                      total;

  // Byte counts, overflow decision and the masked header word.
  always_comb begin
    in_cnt   = BYTE_CNT_WD'(keep_to_count(MAX_KEEP_WD'(keep_in)));
    hdr_cnt  = BYTE_CNT_WD'(keep_to_count(MAX_KEEP_WD'(keep_insert)));
    total    = int'(res_cnt) + int'(in_cnt);
    overflow = total > DATA_BYTE_WD;
    hdr_bits = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      hdr_bits[8*i +: 8] = header_insert[8*i +: 8] & {8{keep_insert[i]}};
    end
  end

  // Realigner inputs: live payload in PASS; in FLUSH the leftover bytes are
  // pre-shifted to the MSB end and presented as a short zero-residual beat.
  always_comb begin
    ra_res  = res_data;
    ra_n    = res_cnt;
    ra_data = data_in;
    ra_m    = in_cnt;
    if (state == FLUSH) begin
      ra_res  = '0;
      ra_n    = '0;
      ra_data = res_data << (8 * (DATA_BYTE_WD - int'(res_cnt)));
      ra_m    = flush_cnt;
    end
  end

  axis_byte_realign #(
    .DATA_WD      (DATA_WD),
    .DATA_BYTE_WD (DATA_BYTE_WD),
    .BYTE_CNT_WD  (BYTE_CNT_WD)
  ) u_realign (
    .residual     (ra_res),
    .n            (ra_n),
    .data_in      (ra_data),
    .m            (ra_m),
    .packed_data  (ra_packed),
    .new_residual (ra_new_res),
    .keep         (ra_keep)
  );

  // State register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      state <= state_nxt;
    end
  end

  // Next state, handshakes and output-register load controls.
  always_comb begin
    state_nxt    = state;
    ready_in     = 1'b0;
    ready_insert = 1'b0;
    load         = 1'b0;
    load_last    = 1'b0;
    can_load     = !valid_out || ready_out;
    case (state)
      IDLE: begin
        // Held low while reset is asserted so the handshake stays quiet.
        ready_insert = !rst_n;
        if (valid_insert && !rst_n) begin
          state_nxt = PASS;
        end
      end
      PASS: begin
        ready_in = can_load;
        if (valid_in && can_load) begin
          load = 1'b1;
          if (last_in) begin
            if (overflow) begin
              state_nxt = FLUSH;
            end else begin
              load_last = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
      end
      FLUSH: begin
        if (can_load) begin
          load      = 1'b1;
          load_last = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign hdr_fire = valid_insert && ready_insert;

  // Residual bytes, flush count and the output register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      res_data  <= '0;
      res_cnt   <= '0;
      flush_cnt <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end else begin
      if (hdr_fire) begin
        res_data <= hdr_bits;
        res_cnt  <= hdr_cnt;
      end
      if (state == PASS && load) begin
        res_data <= ra_new_res;
        if (last_in && overflow) begin
          flush_cnt <= BYTE_CNT_WD'(total - DATA_BYTE_WD);
        end
      end
      if (load) begin
        valid_out <= 1'b1;
        data_out  <= ra_packed;
        keep_out  <= ra_keep;
        last_out  <= load_last;
      end else if (ready_out) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_stream_insert_header.sv
// Directed self-checking bench for axi_stream_insert_header.
module tb_axi_stream_insert_header;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] data_in = '0;
  logic [3:0]  keep_in = '0;
  logic        last_in = 1'b0;
  logic        ready_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out = 1'b1;
  logic        valid_insert = 1'b0;
  logic [31:0] header_insert = '0;
  logic [3:0]  keep_insert = '0;
  logic        ready_insert;

  int checks = 0;
  int errors = 0;

  logic [31:0] got_data [$];
  logic [3:0]  got_keep [$];
  logic        got_last [$];

  logic        stalled_prev = 1'b0;
  logic [31:0] prev_data;
  logic [3:0]  prev_keep;
  logic        prev_last;

  logic [31:0] pd [8];
  logic [3:0]  pk [8];
  logic [31:0] ed [8];
  logic [3:0]  ek [8];

  axi_stream_insert_header #(.DATA_WD(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_in      (valid_in),
    .data_in       (data_in),
    .keep_in       (keep_in),
    .last_in       (last_in),
    .ready_in      (ready_in),
    .valid_out     (valid_out),
    .data_out      (data_out),
    .keep_out      (keep_out),
    .last_out      (last_out),
    .ready_out     (ready_out),
    .valid_insert  (valid_insert),
    .header_insert (header_insert),
    .keep_insert   (keep_insert),
    .ready_insert  (ready_insert)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Collect accepted output beats and verify stability while stalled.
  always @(negedge clk) begin
    if (rst_n) begin
      stalled_prev = 1'b0;
    end else begin
      if (valid_out && ready_out) begin
        got_data.push_back(data_out);
        got_keep.push_back(keep_out);
        got_last.push_back(last_out);
      end
      if (valid_out && !ready_out) begin
        check("stall_ready_in", 32'(ready_in), 32'd0);
        if (stalled_prev) begin
          check("stall_data", data_out, prev_data);
          check("stall_keep", 32'(keep_out), 32'(prev_keep));
          check("stall_last", 32'(last_out), 32'(prev_last));
        end
        stalled_prev = 1'b1;
        prev_data    = data_out;
        prev_keep    = keep_out;
        prev_last    = last_out;
      end else begin
        stalled_prev = 1'b0;
      end
    end
  end

  // Called just after a rising edge; returns just after the handshake edge.
  task automatic send_hdr(input logic [31:0] hdr, input logic [3:0] k);
    int cnt;
    cnt           = 0;
    valid_insert  = 1'b1;
    header_insert = hdr;
    keep_insert   = k;
    @(negedge clk);
    while (!ready_insert && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    if (!ready_insert) check("hdr_timeout", 32'(ready_insert), 32'd1);
    @(posedge clk);
    #1;
    valid_insert = 1'b0;
  endtask

  task automatic send_pkt(input int nb, input logic [31:0] d [8], input logic [3:0] k [8],
                          input bit term);
    int cnt;
    for (int i = 0; i < nb; i++) begin
      cnt      = 0;
      valid_in = 1'b1;
      data_in  = d[i];
      keep_in  = k[i];
      last_in  = term && (i == nb - 1);
      @(negedge clk);
      while (!ready_in && cnt < 100) begin
        @(negedge clk);
        cnt++;
      end
      if (!ready_in) check($sformatf("pay_timeout%0d", i), 32'(ready_in), 32'd1);
      check($sformatf("busy_ready_insert%0d", i), 32'(ready_insert), 32'd0);
      @(posedge clk);
      #1;
    end
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic clear_got();
    got_data.delete();
    got_keep.delete();
    got_last.delete();
  endtask

  task automatic expect_out(input string name, input int nb, input logic [31:0] e_d [8],
                            input logic [3:0] e_k [8]);
    int cnt;
    cnt = 0;
    while (got_data.size() < nb && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    repeat (3) @(negedge clk);
    check({name, "_beats"}, 32'(got_data.size()), 32'(nb));
    for (int i = 0; i < nb && i < got_data.size(); i++) begin
      check($sformatf("%s_data%0d", name, i), got_data[i], e_d[i]);
      check($sformatf("%s_keep%0d", name, i), 32'(got_keep[i]), 32'(e_k[i]));
      check($sformatf("%s_last%0d", name, i), 32'(got_last[i]), 32'(i == nb - 1));
    end
    clear_got();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #1;
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_data_out", data_out, 32'd0);
    check("rst_keep_out", 32'(keep_out), 32'd0);
    check("rst_last_out", 32'(last_out), 32'd0);
    check("rst_ready_in", 32'(ready_in), 32'd0);
    check("rst_ready_insert", 32'(ready_insert), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("idle_ready_insert", 32'(ready_insert), 32'd1);
    check("idle_ready_in", 32'(ready_in), 32'd0);

    // Test 1: 3-byte header, five payload beats, last beat overflows.
    pd = '{32'hA0B0C0D0, 32'hE0F00010, 32'h20304050, 32'h60708090, 32'h00A01234, 0, 0, 0};
    pk = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hC, 0, 0, 0};
    ed = '{32'hE0D0C0A0, 32'hB0C0D0E0, 32'hF0001020, 32'h30405060, 32'h70809000, 32'hA0000000, 0, 0};
    ek = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h8, 0, 0};
    @(posedge clk); #1;
    send_hdr(32'hF0E0D0C0, 4'b0111);
    send_pkt(5, pd, pk, 1'b1);
    expect_out("p1", 6, ed, ek);

    // Test 2: same packet with a 10-cycle downstream stall mid-packet.
    @(posedge clk); #1;
    send_hdr(32'hF0E0D0C0, 4'b0111);
    fork
      send_pkt(5, pd, pk, 1'b1);
      begin
        int cnt;
        cnt = 0;
        while (got_data.size() < 2 && cnt < 200) begin
          @(negedge clk);
          cnt++;
        end
        @(posedge clk);
        #1 ready_out = 1'b0;
        repeat (10) @(posedge clk);
        #1 ready_out = 1'b1;
      end
    join
    expect_out("stall", 6, ed, ek);

    // Test 3: full 4-byte header, single full last beat.
    pd = '{32'hAABBCCDD, 0, 0, 0, 0, 0, 0, 0};
    pk = '{4'hF, 0, 0, 0, 0, 0, 0, 0};
    ed = '{32'h11223344, 32'hAABBCCDD, 0, 0, 0, 0, 0, 0};
    ek = '{4'hF, 4'hF, 0, 0, 0, 0, 0, 0};
    @(posedge clk); #1;
    send_hdr(32'h11223344, 4'b1111);
    send_pkt(1, pd, pk, 1'b1);
    expect_out("full_hdr", 2, ed, ek);

    // Test 4: empty header, payload passes unchanged.
    pd = '{32'h01020304, 32'h05060708, 0, 0, 0, 0, 0, 0};
    pk = '{4'hF, 4'h8, 0, 0, 0, 0, 0, 0};
    ed = '{32'h01020304, 32'h05000000, 0, 0, 0, 0, 0, 0};
    ek = '{4'hF, 4'h8, 0, 0, 0, 0, 0, 0};
    @(posedge clk); #1;
    send_hdr(32'hDEADBEEF, 4'b0000);
    send_pkt(2, pd, pk, 1'b1);
    expect_out("no_hdr", 2, ed, ek);

    // Test 5: payload offered before the header; n+m exactly fills one beat.
    pd = '{32'h11223344, 0, 0, 0, 0, 0, 0, 0};
    pk = '{4'hE, 0, 0, 0, 0, 0, 0, 0};
    ed = '{32'hAB112233, 0, 0, 0, 0, 0, 0, 0};
    ek = '{4'hF, 0, 0, 0, 0, 0, 0, 0};
    @(posedge clk); #1;
    valid_in = 1'b1;
    data_in  = 32'h11223344;
    keep_in  = 4'hE;
    last_in  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("early_ready_in%0d", i), 32'(ready_in), 32'd0);
    end
    @(posedge clk); #1;
    send_hdr(32'h000000AB, 4'b0001);
    send_pkt(1, pd, pk, 1'b1);
    expect_out("early", 1, ed, ek);

    // Test 6: reset mid-packet with a beat held in the output register.
    pd = '{32'hA0B0C0D0, 32'hE0F00010, 0, 0, 0, 0, 0, 0};
    pk = '{4'hF, 4'hF, 0, 0, 0, 0, 0, 0};
    @(posedge clk); #1;
    send_hdr(32'hF0E0D0C0, 4'b0111);
    send_pkt(2, pd, pk, 1'b0);
    ready_out = 1'b0;
    #1;
    check("pre_rst_valid_out", 32'(valid_out), 32'd1);
    rst_n = 1'b1;
    #1;
    check("mid_rst_valid_out", 32'(valid_out), 32'd0);
    check("mid_rst_data_out", data_out, 32'd0);
    check("mid_rst_keep_out", 32'(keep_out), 32'd0);
    check("mid_rst_last_out", 32'(last_out), 32'd0);
    check("mid_rst_ready_in", 32'(ready_in), 32'd0);
    check("mid_rst_ready_insert", 32'(ready_insert), 32'd0);
    ready_out = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    clear_got();
    @(negedge clk);
    check("post_rst_ready_insert", 32'(ready_insert), 32'd1);
    check("post_rst_valid_out", 32'(valid_out), 32'd0);

    pd = '{32'hAABBCCDD, 0, 0, 0, 0, 0, 0, 0};
    pk = '{4'hF, 0, 0, 0, 0, 0, 0, 0};
    ed = '{32'h11223344, 32'hAABBCCDD, 0, 0, 0, 0, 0, 0};
    ek = '{4'hF, 4'hF, 0, 0, 0, 0, 0, 0};
    @(posedge clk); #1;
    send_hdr(32'h11223344, 4'b1111);
    send_pkt(1, pd, pk, 1'b1);
    expect_out("post_rst", 2, ed, ek);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_stream_insert_header.md
Name: axi_stream_insert_header

Overview:
AXI-Stream header inserter. It prepends the valid bytes of a one-word header to an AXI-Stream packet and re-packs the byte stream so every output beat is full except the last. It sits between a payload source and a downstream AXI-Stream sink.

Parameters:
DATA_WD, 32, data bus width in bits (multiple of 8)
DATA_BYTE_WD, DATA_WD/8, keep width / bytes per beat
BYTE_CNT_WD, $clog2(DATA_BYTE_WD)+1, width of internal byte counters

Ports:
clk  in  1  clock; all logic on the rising edge
rst_n  in  1  reset; asynchronous, active-high (asserting rst_n=1 resets; name kept per codebase)
valid_in  in  1  payload beat valid
data_in  in  DATA_WD  payload data; bits [DATA_WD-1:DATA_WD-8] are the first byte on the wire
keep_in  in  DATA_BYTE_WD  payload byte enables; all ones except on last beat, where ones are contiguous from the MSB
last_in  in  1  last payload beat
ready_in  out  1  payload beat accepted when valid_in&ready_in
valid_out  out  1  output beat valid
data_out  out  DATA_WD  output data, same byte order
keep_out  out  DATA_BYTE_WD  all ones except on last beat (MSB-contiguous)
last_out  out  1  last output beat
ready_out  in  1  downstream ready
valid_insert  in  1  header valid
header_insert  in  DATA_WD  header word
keep_insert  in  DATA_BYTE_WD  header byte enables, contiguous from the LSB (0000, 0001, 0011, 0111, 1111)
ready_insert  out  1  header accepted when valid_insert&ready_insert

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: valid_out=0, data_out=0, keep_out=0, last_out=0, ready_in=0, ready_insert=0; state=IDLE; residual register and counts cleared.
- States: IDLE, PASS, FLUSH.
- IDLE: ready_insert=1, ready_in=0. On header handshake: capture the low n header bytes into the residual register (n = popcount(keep_insert)), then go to PASS. Payload is never accepted before its header.
- PASS:
  - ready_insert=0.
  - ready_in = !valid_out | ready_out.
  - Each accepted beat with m valid bytes loads the output register with {residual n bytes, first DATA_BYTE_WD-n bytes of data_in}; the residual becomes the last n bytes of data_in.
  - Not last beat: keep_out all ones.
  - Last beat with n+m <= DATA_BYTE_WD: single output beat, last_out=1, keep_out = top n+m bits set, data below is zero; next state IDLE.
  - Last beat with n+m > DATA_BYTE_WD: full beat with last_out=0; next state FLUSH.
- FLUSH: ready_in=0. When the output register frees, emit the residual n+m-DATA_BYTE_WD bytes MSB-aligned, last_out=1, matching keep_out; then IDLE.
- Output register: valid_out is set on load and cleared on a valid_out&ready_out handshake with no new load. While valid_out=1 and ready_out=0, data_out/keep_out/last_out hold stable.
- Latency: first output beat is valid the cycle after the first payload handshake. Throughput is one beat per cycle with ready_out=1.
- n=0: payload passes unchanged with 1-cycle latency. n=DATA_BYTE_WD: the header is a full first beat and the payload is delayed one beat.
- A new header is accepted only in IDLE, i.e. after the final output beat has been loaded and the stage can accept. Back-to-back packets are allowed once in IDLE.
- valid_insert and valid_in both high in IDLE: only the header is taken; the payload waits.
- Reset mid-packet: state, residual and output register are discarded immediately; outputs return to reset values.

Decomposition:
- Shared package: DATA_WD default, state enum (IDLE/PASS/FLUSH), popcount/keep-mask helper functions (count to mask, mask to count).
- One natural sub-module: axis_byte_realign. It is combinational; inputs are residual, n, data_in and m; outputs are the packed word, new residual and keep. It sits under the FSM and output register in the top.

Test Plan:
- Header F0E0D0C0, keep_insert 0111; payload A0B0C0D0, E0F00010, 20304050, 60708090, 00A0xxxx (keep 1100, last); ready_out=1 -> data_out E0D0C0A0, B0C0D0E0, F0001020, 30405060, 70809000 (keep 1111), then A0000000 keep 1000 last_out=1.
- Same packet, ready_out low for 10 mid-packet cycles -> outputs held stable, ready_in=0 while the register is full, no bytes lost or duplicated, identical byte sequence.
- keep_insert 1111, header 11223344, payload one beat AABBCCDD keep 1111 last -> 11223344 keep 1111, then AABBCCDD keep 1111 last.
- keep_insert 0000, payload 01020304, 05060708 (keep 1000, last) -> payload is output unchanged, last beat 05000000 keep 1000 last.
- valid_in asserted before valid_insert -> ready_in stays 0 until the header handshake; ready_insert=0 until the previous last_out beat has been loaded.
- Assert rst_n=1 mid-packet -> valid_out=0 and ready_in=0 immediately; after release, ready_insert=1 and a fresh packet is correct.
